bank_snapshot_arbiter: RTL and testbench
========================================

Name: bank_snapshot_arbiter

Overview:
- Owns the single port of the shared 16x8 clock/chrono register bank and arbitrates it between the control FSM (writer) and a frame-synchronous snapshot engine.
- At each frame start it copies bank entries FIRST_ADDR..LAST_ADDR (seconds through cursor) into a double-buffered shadow file.
- The VGA pointer unit reads the shadow file instead of the bank, so every frame displays one atomic, consistent set of values.

Parameters:
- ADDR_W, 4, bank address width.
- DATA_W, 8, bank data width.
- FIRST_ADDR, 1, first entry copied by a snapshot.
- LAST_ADDR, 12, last entry copied by a snapshot (inclusive).

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- FrameStart  in  1  one-cycle pulse while PosX==0 && PosY==0.
- WrReq  in  1  writer request; held high until WrAck.
- WrAddr  in  ADDR_W  write address; stable while WrReq is high.
- WrData  in  DATA_W  write data; stable while WrReq is high.
- WrAck  out  1  one-cycle pulse; write performed this cycle.
- BankAddr  out  ADDR_W  bank address.
- BankWrData  out  DATA_W  bank write data.
- BankWE  out  1  bank write enable.
- BankRdData  in  DATA_W  bank read data, valid one cycle after BankAddr is presented.
- ShadowAddr  in  ADDR_W  shadow read address from the VGA pointer unit.
- ShadowData  out  DATA_W  committed shadow entry; combinational read.
- SnapBusy  out  1  high while a snapshot is in progress.
- SnapDone  out  1  one-cycle pulse when the new shadow contents are committed.
- Overrun  out  1  one-cycle pulse when FrameStart arrives while a snapshot is busy or pending.

Behaviour:
- Reset (RESET low, asynchronous):
  - state=IDLE, ptr=FIRST_ADDR, pending=0, fair=0.
  - Staging and committed arrays cleared to 0.
  - All outputs 0; ShadowData reads 0.
- States: IDLE, WRITE, RD_ISSUE, RD_CAPTURE.
- WRITE:
  - BankAddr=WrAddr, BankWrData=WrData, BankWE=1, WrAck=1, all for exactly this one cycle.
  - Next state: RD_ISSUE if a snapshot is active or pending, else IDLE.
  - WRITE never follows WRITE directly, so a held WrReq cannot cause a double write.
- RD_ISSUE: BankAddr=ptr, BankWE=0. Next state is RD_CAPTURE.
- RD_CAPTURE:
  - staging[ptr] <= BankRdData.
  - If ptr==LAST_ADDR: copy staging to the committed array, ptr=FIRST_ADDR, SnapDone=1 in the next cycle, go to IDLE (or WRITE if WrReq is high).
  - Else: ptr++, set fair=0, then go to WRITE if WrReq is high, else RD_ISSUE.
- IDLE:
  - WrReq high: go to WRITE. If FrameStart is also high, set pending=1.
  - Else FrameStart or pending high: go to RD_ISSUE and clear pending.
- Priority and fairness:
  - The writer is granted only from IDLE or RD_CAPTURE.
  - At least one full entry read occurs between consecutive writes while a snapshot is active. Worst-case snapshot length is 12*(2+1)=36 cycles.
- Snapshot latency with no writes: FrameStart sampled at edge E0; reads span 24 cycles; SnapDone is high in cycle 25.
- SnapBusy is high from the cycle after FrameStart is accepted (or pending is set) until the cycle SnapDone is high; SnapBusy=0 in the SnapDone cycle.
- FrameStart arriving while SnapBusy=1 or pending=1: it is ignored and Overrun pulses once.
- Coherency:
  - Writes never touch the shadow file.
  - A write to an entry not yet captured appears in the current snapshot.
  - A write to an entry already captured appears in the next snapshot.
  - Writes to addresses outside FIRST..LAST go to the bank only.
- Outputs when not in WRITE or RD_ISSUE: BankWE=0, BankAddr=0, BankWrData=0.
- Reset asserted mid-snapshot: the snapshot is aborted and the committed shadow returns to 0. No partial commit is ever visible.

Test Plan:
- Reset, then preload bank[1..12]=8'h10..8'h1B. Pulse FrameStart → BankAddr steps 1..12, one address every 2 cycles; SnapDone in cycle 25; ShadowAddr=5 then reads 8'h14.
- WrReq with WrAddr=3, WrData=8'hA5 while IDLE → WrAck and BankWE high for exactly 1 cycle; bank[3]=8'hA5; shadow[3] unchanged until the next snapshot.
- During a snapshot, write addr 10 when ptr=4 and addr 2 when ptr=6 → shadow[10] takes the new value this frame; shadow[2] keeps the old value until the next frame; SnapDone slips by 2 cycles.
- WrReq held high continuously from FrameStart → writes and entry reads alternate; SnapDone no later than cycle 37.
- FrameStart again 10 cycles after the first → Overrun one-cycle pulse; one SnapDone only.
- Assert RESET low at cycle 15 of a snapshot → outputs 0 asynchronously; ShadowData=0; SnapDone never pulses.

Source files
------------

// File: rtl/bank_snapshot_arbiter.sv
// -----------------------------------------------------------------------------
// bank_snapshot_arbiter
//
// Owns the single port of the shared 16x8 clock/chrono register bank. Arbitrates
// between the control FSM (writer) and a frame-synchronous snapshot engine that
// copies entries FIRST_ADDR..LAST_ADDR into a double-buffered shadow file. The
// VGA pointer unit reads the committed shadow, so each frame sees one atomic set.
//
// Ports:
//   CLK, RESET            clock (rising edge), async active-low reset
//   FrameStart            one-cycle frame start pulse
//   WrReq/WrAddr/WrData   writer request, held until WrAck
//   WrAck                 one-cycle pulse, write performed this cycle
//   BankAddr/BankWrData/BankWE  bank port (registered)
//   BankRdData            bank read data, valid one cycle after BankAddr
//   ShadowAddr/ShadowData committed shadow read (combinational)
//   SnapBusy              snapshot in progress
//   SnapDone              one-cycle pulse when new shadow is committed
//   Overrun               one-cycle pulse when a FrameStart is dropped
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | bank port free, waiting for a write or a frame start
// WRITE      | writer owns the bank for exactly one cycle (WrAck high)
// RD_ISSUE   | snapshot presents BankAddr=ptr
// RD_CAPTURE | snapshot latches BankRdData into staging[ptr]
// -----------------------------------------------------------------------------
module bank_snapshot_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIRST_ADDR = 1,
    parameter int LAST_ADDR  = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FrameStart,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrAck,
    output logic [ADDR_W-1:0] BankAddr,
    output logic [DATA_W-1:0] BankWrData,
    output logic              BankWE,
    input  logic [DATA_W-1:0] BankRdData,
    input  logic [ADDR_W-1:0] ShadowAddr,
    output logic [DATA_W-1:0] ShadowData,
    output logic              SnapBusy,
    output logic              SnapDone,
    output logic              Overrun
);

    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_CAPTURE} state_t;

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              pending;
    logic              fair;
    logic [DATA_W-1:0] staging   [FIRST_ADDR:LAST_ADDR];
    logic [DATA_W-1:0] committed [FIRST_ADDR:LAST_ADDR];

    // A frame start is only taken when no snapshot is running or queued;
    // pending always implies SnapBusy, but both are checked for clarity.
    logic frameAccept;
    assign frameAccept = FrameStart && !SnapBusy && !pending;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            ptr        <= FIRST_A;
            pending    <= 1'b0;
            fair       <= 1'b0;
            WrAck      <= 1'b0;
            BankAddr   <= '0;
            BankWrData <= '0;
            BankWE     <= 1'b0;
            SnapBusy   <= 1'b0;
            SnapDone   <= 1'b0;
            Overrun    <= 1'b0;
            for (int i = FIRST_ADDR; i <= LAST_ADDR; i++) begin
                staging[ADDR_W'(i)]   <= '0;
                committed[ADDR_W'(i)] <= '0;
            end
        end else begin
            // Bank port outputs describe the cycle being entered; idle by default.
            WrAck      <= 1'b0;
            BankAddr   <= '0;
            BankWrData <= '0;
            BankWE     <= 1'b0;
            SnapDone   <= 1'b0;
            Overrun    <= FrameStart && (SnapBusy || pending);

            case (state)
                IDLE: begin
                    if (WrReq && !(fair && SnapBusy)) begin
                        state      <= WRITE;
                        BankAddr   <= WrAddr;
                        BankWrData <= WrData;
                        BankWE     <= 1'b1;
                        WrAck      <= 1'b1;
                        fair       <= 1'b1;
                        if (frameAccept) begin
                            pending  <= 1'b1;
                            SnapBusy <= 1'b1;
                        end
                    end else if (frameAccept || pending) begin
                        state    <= RD_ISSUE;
                        BankAddr <= ptr;
                        pending  <= 1'b0;
                        SnapBusy <= 1'b1;
                    end
                end

                WRITE: begin
                    // Never back to WRITE: a held WrReq cannot double-write.
                    if (frameAccept) begin
                        SnapBusy <= 1'b1;
                    end
                    if (SnapBusy || pending || frameAccept) begin
                        state    <= RD_ISSUE;
                        BankAddr <= ptr;
                        pending  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                RD_ISSUE: begin
                    state <= RD_CAPTURE;
                end

                RD_CAPTURE: begin
                    staging[ptr] <= BankRdData;
                    if (ptr == LAST_A) begin
                        // The last entry is still in flight, take it straight
                        // from the bank so the commit is complete this edge.
                        for (int i = FIRST_ADDR; i <= LAST_ADDR; i++) begin
                            committed[ADDR_W'(i)] <= (i == LAST_ADDR) ? BankRdData
                                                                     : staging[ADDR_W'(i)];
                        end
                        ptr      <= FIRST_A;
                        SnapDone <= 1'b1;
                        SnapBusy <= 1'b0;
                        if (WrReq) begin
                            state      <= WRITE;
                            BankAddr   <= WrAddr;
                            BankWrData <= WrData;
                            BankWE     <= 1'b1;
                            WrAck      <= 1'b1;
                            fair       <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        ptr  <= ptr + 1'b1;
                        fair <= 1'b0;
                        if (WrReq) begin
                            state      <= WRITE;
                            BankAddr   <= WrAddr;
                            BankWrData <= WrData;
                            BankWE     <= 1'b1;
                            WrAck      <= 1'b1;
                            fair       <= 1'b1;
                        end else begin
                            state    <= RD_ISSUE;
                            BankAddr <= ptr + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Entries outside the snapshot window have no shadow and read as 0.
    always_comb begin
        ShadowData = '0;
        if (ShadowAddr >= FIRST_A && ShadowAddr <= LAST_A) begin
            ShadowData = committed[ShadowAddr];
        end
    end

endmodule

// File: tb/tb_bank_snapshot_arbiter.sv
module tb_bank_snapshot_arbiter;

    logic       CLK;
    logic       RESET;
    logic       FrameStart;
    logic       WrReq;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       WrAck;
    logic [3:0] BankAddr;
    logic [7:0] BankWrData;
    logic       BankWE;
    logic [7:0] BankRdData;
    logic [3:0] ShadowAddr;
    logic [7:0] ShadowData;
    logic       SnapBusy;
    logic       SnapDone;
    logic       Overrun;

    int nCompared;
    int nMismatched;

    logic [7:0] mem [0:15];
    logic       preload;

    bank_snapshot_arbiter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FrameStart (FrameStart),
        .WrReq      (WrReq),
        .WrAddr     (WrAddr),
        .WrData     (WrData),
        .WrAck      (WrAck),
        .BankAddr   (BankAddr),
        .BankWrData (BankWrData),
        .BankWE     (BankWE),
        .BankRdData (BankRdData),
        .ShadowAddr (ShadowAddr),
        .ShadowData (ShadowData),
        .SnapBusy   (SnapBusy),
        .SnapDone   (SnapDone),
        .Overrun    (Overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous-read register bank: data valid one cycle after the address.
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= (i >= 1 && i <= 12) ? 8'(8'h0F + i) : 8'h00;
            end
        end else if (BankWE) begin
            mem[BankAddr] <= BankWrData;
        end
        BankRdData <= mem[BankAddr];
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) tick();
        nCompared++;
        if ({WrAck, BankWE, SnapBusy, SnapDone, Overrun} !== 5'b0) begin
            nMismatched++;
            $display("FAIL reset_flags: got %b expected 00000", {WrAck, BankWE, SnapBusy, SnapDone, Overrun});
        end
        nCompared++;
        if ({BankAddr, BankWrData} !== 12'h000) begin
            nMismatched++;
            $display("FAIL reset_bank: got addr %0h data %0h expected 0/0", BankAddr, BankWrData);
        end
        ShadowAddr = 4'd5;
        #1;
        nCompared++;
        if (ShadowData !== 8'h00) begin
            nMismatched++;
            $display("FAIL reset_shadow: got %0h expected 00", ShadowData);
        end
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_snapshot();
        preload = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            if (c <= 24) begin
                nCompared++;
                if (SnapBusy !== 1'b1 || SnapDone !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL snap_busy c%0d: got busy %b done %b expected 1 0", c, SnapBusy, SnapDone);
                end
                if (c % 2 == 1) begin
                    nCompared++;
                    if (BankAddr !== 4'((c + 1) / 2) || BankWE !== 1'b0) begin
                        nMismatched++;
                        $display("FAIL snap_addr c%0d: got addr %0d we %b expected %0d 0", c, BankAddr, BankWE, (c + 1) / 2);
                    end
                end
            end else if (c == 25) begin
                nCompared++;
                if (SnapDone !== 1'b1 || SnapBusy !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL snap_done c25: got done %b busy %b expected 1 0", SnapDone, SnapBusy);
                end
            end else begin
                nCompared++;
                if (SnapDone !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL snap_done_pulse c26: got %b expected 0", SnapDone);
                end
            end
            tick();
        end
        ShadowAddr = 4'd5;
        #1;
        nCompared++;
        if (ShadowData !== 8'h14) begin
            nMismatched++;
            $display("FAIL shadow5: got %0h expected 14", ShadowData);
        end
        ShadowAddr = 4'd1;
        #1;
        nCompared++;
        if (ShadowData !== 8'h10) begin
            nMismatched++;
            $display("FAIL shadow1: got %0h expected 10", ShadowData);
        end
        ShadowAddr = 4'd12;
        #1;
        nCompared++;
        if (ShadowData !== 8'h1B) begin
            nMismatched++;
            $display("FAIL shadow12: got %0h expected 1b", ShadowData);
        end
        ShadowAddr = 4'd13;
        #1;
        nCompared++;
        if (ShadowData !== 8'h00) begin
            nMismatched++;
            $display("FAIL shadow13: got %0h expected 00", ShadowData);
        end
        tick();
    endtask

    task automatic test_idle_write();
        WrReq  = 1'b1;
        WrAddr = 4'd3;
        WrData = 8'hA5;
        tick();
        nCompared++;
        if ({WrAck, BankWE} !== 2'b11 || BankAddr !== 4'd3 || BankWrData !== 8'hA5) begin
            nMismatched++;
            $display("FAIL idle_write: got ack %b we %b addr %0d data %0h expected 1 1 3 a5", WrAck, BankWE, BankAddr, BankWrData);
        end
        WrReq = 1'b0;
        tick();
        nCompared++;
        if ({WrAck, BankWE} !== 2'b00) begin
            nMismatched++;
            $display("FAIL idle_write_pulse: got ack %b we %b expected 0 0", WrAck, BankWE);
        end
        nCompared++;
        if (mem[3] !== 8'hA5) begin
            nMismatched++;
            $display("FAIL idle_write_bank: got %0h expected a5", mem[3]);
        end
        ShadowAddr = 4'd3;
        #1;
        nCompared++;
        if (ShadowData !== 8'h12) begin
            nMismatched++;
            $display("FAIL idle_write_shadow: got %0h expected 12", ShadowData);
        end
        tick();
    endtask

    task automatic test_coherency();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            WrReq  = (c == 8) || (c == 13);
            WrAddr = (c == 13) ? 4'd2 : 4'd10;
            WrData = (c == 13) ? 8'h5A : 8'hC3;
            if (c == 9 || c == 14) begin
                nCompared++;
                if (WrAck !== 1'b1 || BankAddr !== ((c == 9) ? 4'd10 : 4'd2)) begin
                    nMismatched++;
                    $display("FAIL coh_write c%0d: got ack %b addr %0d", c, WrAck, BankAddr);
                end
            end
            if (c == 10) begin
                nCompared++;
                if (BankAddr !== 4'd5 || BankWE !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL coh_resume: got addr %0d we %b expected 5 0", BankAddr, BankWE);
                end
            end
            if (c == 26 || c == 27) begin
                nCompared++;
                if (SnapDone !== (c == 27) || SnapBusy !== (c == 26)) begin
                    nMismatched++;
                    $display("FAIL coh_done c%0d: got done %b busy %b", c, SnapDone, SnapBusy);
                end
            end
            tick();
        end
        WrReq = 1'b0;
        ShadowAddr = 4'd10;
        #1;
        nCompared++;
        if (ShadowData !== 8'hC3) begin
            nMismatched++;
            $display("FAIL coh_shadow10: got %0h expected c3", ShadowData);
        end
        ShadowAddr = 4'd2;
        #1;
        nCompared++;
        if (ShadowData !== 8'h11) begin
            nMismatched++;
            $display("FAIL coh_shadow2_old: got %0h expected 11", ShadowData);
        end
        ShadowAddr = 4'd3;
        #1;
        nCompared++;
        if (ShadowData !== 8'hA5) begin
            nMismatched++;
            $display("FAIL coh_shadow3: got %0h expected a5", ShadowData);
        end
        tick();
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        repeat (26) tick();
        ShadowAddr = 4'd2;
        #1;
        nCompared++;
        if (ShadowData !== 8'h5A) begin
            nMismatched++;
            $display("FAIL coh_shadow2_new: got %0h expected 5a", ShadowData);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks   = 0;
        WrAddr = 4'd14;
        WrData = 8'hEE;
        WrReq  = 1'b1;
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        nCompared++;
        if (SnapBusy !== 1'b1) begin
            nMismatched++;
            $display("FAIL b2b_pending_busy: got %b expected 1", SnapBusy);
        end
        for (int c = 1; c <= 37; c++) begin
            nCompared++;
            if (WrAck !== (c % 3 == 1) || SnapDone !== (c == 37)) begin
                nMismatched++;
                $display("FAIL b2b_seq c%0d: got ack %b done %b expected %b %b", c, WrAck, SnapDone, (c % 3 == 1), (c == 37));
            end
            if (WrAck === 1'b1) acks++;
            tick();
        end
        WrReq = 1'b0;
        nCompared++;
        if (acks != 13) begin
            nMismatched++;
            $display("FAIL b2b_ack_count: got %0d expected 13", acks);
        end
        tick();
        nCompared++;
        if (mem[14] !== 8'hEE || WrAck !== 1'b0) begin
            nMismatched++;
            $display("FAIL b2b_bank14: got %0h ack %b expected ee 0", mem[14], WrAck);
        end
        ShadowAddr = 4'd14;
        #1;
        nCompared++;
        if (ShadowData !== 8'h00) begin
            nMismatched++;
            $display("FAIL b2b_shadow14: got %0h expected 00", ShadowData);
        end
        ShadowAddr = 4'd10;
        #1;
        nCompared++;
        if (ShadowData !== 8'hC3) begin
            nMismatched++;
            $display("FAIL b2b_shadow10: got %0h expected c3", ShadowData);
        end
        tick();
    endtask

    task automatic test_overrun();
        int overruns;
        int dones;
        int doneCycle;
        overruns  = 0;
        dones     = 0;
        doneCycle = -1;
        FrameStart = 1'b1;
        tick();
        for (int c = 1; c <= 32; c++) begin
            FrameStart = (c == 10);
            nCompared++;
            if (Overrun !== (c == 11)) begin
                nMismatched++;
                $display("FAIL overrun c%0d: got %b expected %b", c, Overrun, (c == 11));
            end
            if (Overrun === 1'b1) overruns++;
            if (SnapDone === 1'b1) begin
                dones++;
                doneCycle = c;
            end
            tick();
        end
        FrameStart = 1'b0;
        nCompared++;
        if (overruns != 1) begin
            nMismatched++;
            $display("FAIL overrun_count: got %0d expected 1", overruns);
        end
        nCompared++;
        if (dones != 1 || doneCycle != 25) begin
            nMismatched++;
            $display("FAIL overrun_done: got %0d pulses at c%0d expected 1 at c25", dones, doneCycle);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        repeat (14) tick();
        ShadowAddr = 4'd5;
        RESET = 1'b0;
        #1;
        nCompared++;
        if ({WrAck, BankWE, SnapBusy, SnapDone, Overrun} !== 5'b0 || BankAddr !== 4'd0 || BankWrData !== 8'h00) begin
            nMismatched++;
            $display("FAIL reset_mid_outputs: got flags %b addr %0d data %0h expected 0", {WrAck, BankWE, SnapBusy, SnapDone, Overrun}, BankAddr, BankWrData);
        end
        nCompared++;
        if (ShadowData !== 8'h00) begin
            nMismatched++;
            $display("FAIL reset_mid_shadow: got %0h expected 00", ShadowData);
        end
        #2;
        RESET = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (SnapDone === 1'b1) dones++;
        end
        nCompared++;
        if (dones != 0 || SnapBusy !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_mid_nodone: got %0d pulses busy %b expected 0 0", dones, SnapBusy);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        RESET      = 1'b0;
        FrameStart = 1'b0;
        WrReq      = 1'b0;
        WrAddr     = 4'd0;
        WrData     = 8'h00;
        ShadowAddr = 4'd0;
        preload    = 1'b0;

        test_reset();
        test_snapshot();
        test_idle_write();
        test_coherency();
        test_back_to_back();
        test_overrun();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
